// File: rtl/gte_pkg.sv
// Shared GTE definitions: FSM state type and default ORGB pack geometry.
package gte_pkg;

  // Conversion sequencer states: waiting, converting one channel per cycle, presenting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } satpack_state_t;

  // Default geometry reproducing the legacy 16->5 colour clamp (IR1..IR3 -> ORGB).
  localparam int GTE_ORGB_CH    = 3;
  localparam int GTE_ORGB_IN_W  = 16;
  localparam int GTE_ORGB_OUT_W = 5;
  localparam int GTE_ORGB_SHIFT = 7;

endpackage

// File: rtl/gte_sat_pack_seq_if.sv
// Valid/ready bus of the saturating pack unit: upstream word in, packed word and flags out.
interface gte_sat_pack_seq_if
  import gte_pkg::*;
#(
  parameter int CH    = GTE_ORGB_CH,
  parameter int IN_W  = GTE_ORGB_IN_W,
  parameter int OUT_W = GTE_ORGB_OUT_W
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_sf;
  logic [CH*IN_W-1:0]    i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [CH*OUT_W-1:0]   o_data;
  logic [CH-1:0]         o_sat;
  logic [CH-1:0]         o_sat_sticky;
  logic                  i_clr_sticky;

  // Driver side (upstream producer plus downstream consumer).
  modport master (
    output i_valid, i_sf, i_data, i_ready, i_clr_sticky,
    input  o_ready, o_valid, o_data, o_sat, o_sat_sticky
  );

  // The pack unit itself.
  modport slave (
    input  i_valid, i_sf, i_data, i_ready, i_clr_sticky,
    output o_ready, o_valid, o_data, o_sat, o_sat_sticky
  );
endinterface

// File: rtl/gte_shift_clamp.sv
// Single-channel optional arithmetic shift followed by clamp to an unsigned OUT_W range.
module gte_shift_clamp #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 5,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0] v,
  input  logic                   sf,
  output logic [OUT_W-1:0]       out,
  output logic                   sat
);
  // Largest representable output, held at input width so the compare stays signed.
  localparam logic signed [IN_W-1:0] MAX_S = IN_W'((1 << OUT_W) - 1);

  logic signed [IN_W-1:0] t;

  assign t = sf ? (v >>> SHIFT) : v;

  // Negative values floor at zero, values above the range pin at all-ones.
  always_comb begin
    out = t[OUT_W-1:0];
    sat = 1'b0;
    if (t < 0) begin
      out = '0;
      sat = 1'b1;
    end else if (t > MAX_S) begin
      out = '1;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/gte_sat_pack_seq.sv
// Time-multiplexed shift/clamp/pack of CH signed channels into one packed word.
// One shared clamp unit converts channel k on CONV cycle k; the word is then held until taken.
module gte_sat_pack_seq
  import gte_pkg::*;
#(
  parameter int CH    = GTE_ORGB_CH,
  parameter int IN_W  = GTE_ORGB_IN_W,
  parameter int OUT_W = GTE_ORGB_OUT_W,
  parameter int SHIFT = GTE_ORGB_SHIFT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  gte_sat_pack_seq_if.slave   bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(CH - 1);

  satpack_state_t         state_q, state_d;
  logic [CW-1:0]          k_q, k_d;
  logic [CH*IN_W-1:0]     data_q, data_d;
  logic                   sf_q, sf_d;
  logic [CH*OUT_W-1:0]    out_q, out_d;
  logic [CH-1:0]          sat_q, sat_d;
  logic [CH-1:0]          sticky_q, sticky_d;

  logic                   accept;
  logic                   wr_en;
  logic [CH-1:0]          wr_sel;
  logic [IN_W-1:0]        ch_v [CH];
  logic [IN_W-1:0]        cur_v;
  logic [OUT_W-1:0]       clamp_out;
  logic                   clamp_sat;

  // A new word may enter when idle, or when the held result leaves this very cycle.
  assign bus.o_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.i_ready);
  assign accept      = bus.i_valid & bus.o_ready;

  assign bus.o_valid      = (state_q == HOLD);
  assign bus.o_data       = out_q;
  assign bus.o_sat        = sat_q;
  assign bus.o_sat_sticky = sticky_q;

  // Unpack the held word so the shared unit can pick channel k.
  for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
    assign ch_v[gi] = data_q[gi*IN_W +: IN_W];
  end

  assign cur_v = ch_v[k_q];

  gte_shift_clamp #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_clamp (
    .v   (cur_v),
    .sf  (sf_q),
    .out (clamp_out),
    .sat (clamp_sat)
  );

  // Per-channel result/flag update; a same-cycle set beats the sticky clear.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    assign wr_sel[gi] = wr_en & (k_q == CW'(gi));
    assign out_d[gi*OUT_W +: OUT_W] = wr_sel[gi] ? clamp_out : out_q[gi*OUT_W +: OUT_W];
    assign sat_d[gi]    = wr_sel[gi] ? clamp_sat : sat_q[gi];
    assign sticky_d[gi] = (sticky_q[gi] & ~bus.i_clr_sticky) | (wr_sel[gi] & clamp_sat);
  end

  // Sequencer next state: channel counter advance, input capture on accept.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wr_en   = 1'b0;
    data_d  = data_q;
    sf_d    = sf_q;
    if (accept) begin
      data_d = bus.i_data;
      sf_d   = bus.i_sf;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CONV;
          k_d     = '0;
        end
      end
      CONV: begin
        wr_en = 1'b1;
        if (k_q == K_LAST) begin
          state_d = HOLD;
          k_d     = '0;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      HOLD: begin
        if (bus.i_ready) begin
          if (accept) begin
            state_d = CONV;
            k_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Sequencer state and channel counter; reset drops any word in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Input holding register, packed result and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q   <= '0;
      sf_q     <= 1'b0;
      out_q    <= '0;
      sat_q    <= '0;
      sticky_q <= '0;
    end else begin
      data_q   <= data_d;
      sf_q     <= sf_d;
      out_q    <= out_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_gte_sat_pack_seq.sv
// Directed bench for gte_sat_pack_seq: default ORGB geometry plus a CH=4/OUT_W=8/SHIFT=4 instance.
module tb_gte_sat_pack_seq;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sat;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  gte_sat_pack_seq_if #(.CH(3), .IN_W(16), .OUT_W(5)) bus_a ();
  gte_sat_pack_seq_if #(.CH(4), .IN_W(16), .OUT_W(8)) bus_b ();

  gte_sat_pack_seq #(.CH(3), .IN_W(16), .OUT_W(5), .SHIFT(7)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  gte_sat_pack_seq #(.CH(4), .IN_W(16), .OUT_W(8), .SHIFT(4)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] d, input logic [3:0] s, input int l);
    exp_t e;
    e.data = d;
    e.sat  = s;
    e.lat  = l;
    return e;
  endfunction

  // Reference clamp for the default geometry (3 x 16 -> 3 x 5, shift 7).
  function automatic exp_t model_a(input logic [47:0] d, input logic sf);
    exp_t e;
    int   v;
    e.data = '0;
    e.sat  = '0;
    e.lat  = 4;
    for (int k = 0; k < 3; k++) begin
      v = int'($signed(d[k*16 +: 16]));
      if (sf) v = v >>> 7;
      if (v < 0) begin
        e.sat[k] = 1'b1;
      end else if (v > 31) begin
        e.data[k*5 +: 5] = 5'd31;
        e.sat[k] = 1'b1;
      end else begin
        e.data[k*5 +: 5] = 5'(v);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word from a negedge until accepted; returns at the negedge after the accept edge.
  task automatic accept_a(input logic [47:0] d, input logic sf);
    bit ok;
    ok = 1'b0;
    bus_a.i_data  = d;
    bus_a.i_sf    = sf;
    bus_a.i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus_a.o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("a_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    bus_a.i_valid = 1'b0;
    $display("a: word %h sf=%0d accepted", d, sf);
  endtask

  task automatic recv_a(input string tag);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.o_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    if (got && q_a.size() > 0) begin
      e = q_a.pop_front();
      check({tag, "_data"}, 64'(bus_a.o_data), 64'(e.data));
      check({tag, "_sat"}, 64'(bus_a.o_sat), 64'(e.sat));
      check({tag, "_lat"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
      $display("a: %s data=%h sat=%b lat=%0d", tag, bus_a.o_data, bus_a.o_sat, cyc - acc_cyc + 1);
    end
  endtask

  task automatic accept_b(input logic [63:0] d, input logic sf);
    bit ok;
    ok = 1'b0;
    bus_b.i_data  = d;
    bus_b.i_sf    = sf;
    bus_b.i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus_b.o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("b_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    bus_b.i_valid = 1'b0;
    $display("b: word %h sf=%0d accepted", d, sf);
  endtask

  task automatic recv_b(input string tag);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_b.o_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    if (got && q_b.size() > 0) begin
      e = q_b.pop_front();
      check({tag, "_data"}, 64'(bus_b.o_data), 64'(e.data));
      check({tag, "_sat"}, 64'(bus_b.o_sat), 64'(e.sat));
      check({tag, "_lat"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
      $display("b: %s data=%h sat=%b lat=%0d", tag, bus_b.o_data, bus_b.o_sat, cyc - acc_cyc + 1);
    end
  endtask

  initial begin
    logic [47:0] rd;
    logic        rsf;

    rst = 1'b1;
    bus_a.i_valid = 1'b0; bus_a.i_sf = 1'b0; bus_a.i_data = '0;
    bus_a.i_ready = 1'b1; bus_a.i_clr_sticky = 1'b0;
    bus_b.i_valid = 1'b0; bus_b.i_sf = 1'b0; bus_b.i_data = '0;
    bus_b.i_ready = 1'b1; bus_b.i_clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_valid", 64'(bus_a.o_valid), 64'd0);
    check("rst_ready", 64'(bus_a.o_ready), 64'd1);
    check("rst_data", 64'(bus_a.o_data), 64'd0);
    check("rst_sat", 64'(bus_a.o_sat), 64'd0);
    check("rst_sticky", 64'(bus_a.o_sat_sticky), 64'd0);

    // 1) sf=1, {0x1000, 0xFF80, 0x0F80}.
    q_a.push_back(mk(32'h7C1F, 4'b0110, 4));
    accept_a({16'h1000, 16'hFF80, 16'h0F80}, 1'b1);
    recv_a("t1");
    @(negedge clk);

    // 2) sf=0, {40, 0x8000, 20}.
    q_a.push_back(mk(32'h7C14, 4'b0110, 4));
    accept_a({16'd40, 16'h8000, 16'd20}, 1'b0);
    recv_a("t2");
    @(negedge clk);

    // 3) Downstream stalls in HOLD; then release with a new word in the same cycle.
    bus_a.i_ready = 1'b0;
    q_a.push_back(mk(32'h2820, 4'b0001, 4));
    accept_a({16'h0500, 16'h0080, 16'hFFFF}, 1'b1);
    recv_a("t3");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 64'(bus_a.o_valid), 64'd1);
      check("t3_hold_data", 64'(bus_a.o_data), 64'h2820);
      check("t3_hold_sat", 64'(bus_a.o_sat), 64'b001);
      check("t3_hold_ready", 64'(bus_a.o_ready), 64'd0);
    end
    bus_a.i_ready = 1'b1;
    #1;
    check("t3_ready_release", 64'(bus_a.o_ready), 64'd1);
    q_a.push_back(mk(32'h0C41, 4'b0000, 4));
    accept_a({16'd3, 16'd2, 16'd1}, 1'b0);
    check("t3_old_word_gone", 64'(bus_a.o_valid), 64'd0);
    recv_a("t3b");
    @(negedge clk);

    // 4) Sticky: set and clear on the same edge, then a plain clear.
    check("t4_sticky_pre", 64'(bus_a.o_sat_sticky), 64'b111);
    q_a.push_back(mk(32'h1407, 4'b0010, 4));
    accept_a({16'd5, 16'hFFFF, 16'd7}, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus_a.i_clr_sticky = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.i_clr_sticky = 1'b0;
    check("t4_sticky_setwins", 64'(bus_a.o_sat_sticky), 64'b010);
    recv_a("t4");
    @(negedge clk);
    bus_a.i_clr_sticky = 1'b1;
    @(negedge clk);
    bus_a.i_clr_sticky = 1'b0;
    check("t4_sticky_clear", 64'(bus_a.o_sat_sticky), 64'b000);

    // 5) Reset while converting channel 1: word dropped, flags cleared.
    accept_a({16'h1000, 16'h1000, 16'h1000}, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t5_sticky_before", 64'(bus_a.o_sat_sticky), 64'b001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_valid", 64'(bus_a.o_valid), 64'd0);
    check("t5_ready", 64'(bus_a.o_ready), 64'd1);
    check("t5_sat", 64'(bus_a.o_sat), 64'd0);
    check("t5_sticky", 64'(bus_a.o_sat_sticky), 64'd0);
    check("t5_data", 64'(bus_a.o_data), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_output", 64'(bus_a.o_valid), 64'd0);
    end

    // Random words against the reference clamp.
    for (int i = 0; i < 6; i++) begin
      rd  = {16'($urandom), 16'($urandom), 16'($urandom)};
      rsf = 1'($urandom_range(0, 1));
      q_a.push_back(model_a(rd, rsf));
      accept_a(rd, rsf);
      recv_a("rand");
      @(negedge clk);
    end

    // 6) CH=4, OUT_W=8, SHIFT=4.
    q_b.push_back(mk(32'hFFFF1000, 4'b1001, 5));
    accept_b({16'h1000, 16'h0FF0, 16'h0100, 16'hF000}, 1'b1);
    recv_b("t6a");
    @(negedge clk);
    q_b.push_back(mk(32'hFFFFFFFF, 4'b0000, 5));
    accept_b({16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0}, 1'b1);
    recv_b("t6b");
    @(negedge clk);
    check("t6_sticky", 64'(bus_b.o_sat_sticky), 64'b1001);

    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
